// File: rtl/out_channel_drain_if.sv
// out_channel_drain_if
//
// Groups every non-clock signal of the output-channel drain stage.
//
// Parameters:
//   MemoryElementWidth - width of each channel word
//   NOut               - buffer depth in words
//
// Signals:
//   outWrite, outData, finished  - from the program-execution machine
//   streamReady                  - from the stream consumer
//   streamValid, streamData,
//   streamLast                   - valid/ready output stream
//   full, count, overflow, done,
//   checksum                     - status
//
// Modports:
//   slave  - the drain stage itself
//   master - whoever drives the machine side and consumes the stream
interface out_channel_drain_if #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut = 6
);
    logic                            outWrite;
    logic [MemoryElementWidth-1:0]   outData;
    logic                            finished;
    logic                            streamReady;
    logic                            streamValid;
    logic [MemoryElementWidth-1:0]   streamData;
    logic                            streamLast;
    logic                            full;
    logic [$clog2(NOut+1)-1:0]       count;
    logic                            overflow;
    logic                            done;
    logic [MemoryElementWidth-1:0]   checksum;

    modport slave (
        input  outWrite, outData, finished, streamReady,
        output streamValid, streamData, streamLast, full, count,
               overflow, done, checksum
    );

    modport master (
        output outWrite, outData, finished, streamReady,
        input  streamValid, streamData, streamLast, full, count,
               overflow, done, checksum
    );
endinterface

// File: rtl/out_channel_drain.sv
// out_channel_drain
//
// Captures words emitted by the machine's `out` instruction into a circular
// buffer of NOut entries and streams them in order over valid/ready. Once the
// machine reports `finished`, the remaining words are drained, the final one
// is flagged with streamLast, and `done` is raised.
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - out_channel_drain_if.slave (machine side, stream side, status)
//
// Optional feature macro: OUT_CHANNEL_DRAIN_CHECKSUM_EN
//   defined   - checksum accumulates every accepted stream word mod 2^W
//   undefined - checksum is tied to zero
module out_channel_drain #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut = 6
) (
    input  logic                clock,
    input  logic                reset,
    out_channel_drain_if.slave  bus
);
    localparam int W  = MemoryElementWidth;
    localparam int PW = $clog2(NOut);
    localparam int CW = $clog2(NOut + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          st;
    logic [W-1:0]    mem [NOut];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   cnt;
    logic            overflow_r;
    logic            done_r;

    logic            valid;
    logic            is_full;
    logic            rd_en;
    logic            wr_req;
    logic            wr_en;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NOut - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid   = (cnt != '0);
    assign is_full = (cnt == CW'(NOut));
    assign rd_en   = valid && bus.streamReady;
    // Writes are only considered while running; a full buffer still accepts
    // a write when a read frees the oldest slot on the same edge.
    assign wr_req  = bus.outWrite && (st == RUN);
    assign wr_en   = wr_req && (!is_full || rd_en);

    // Storage carries no reset: contents are meaningless while count is 0.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wp] <= bus.outData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) begin
                wp <= next_ptr(wp);
            end
            if (rd_en) begin
                rp <= next_ptr(rp);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Run/drain/done sequencing with registered overflow and done flags.
    // DRAIN waits for an empty buffer as seen after the last read's edge,
    // so done rises one edge after that read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st         <= RUN;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (st)
                RUN: begin
                    if (wr_req && !wr_en) begin
                        overflow_r <= 1'b1;
                    end
                    if (bus.finished) begin
                        st <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        st     <= DONE;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    st <= DONE;
                end
                default: begin
                    st <= RUN;
                end
            endcase
        end
    end

`ifdef OUT_CHANNEL_DRAIN_CHECKSUM_EN
    logic [W-1:0] csum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (rd_en) begin
            csum <= csum + mem[rp];
        end
    end

    assign bus.checksum = csum;
`else
    assign bus.checksum = '0;
`endif

    assign bus.streamValid = valid;
    assign bus.streamData  = mem[rp];
    assign bus.streamLast  = (st == DRAIN) && (cnt == CW'(1));
    assign bus.full        = is_full;
    assign bus.count       = cnt;
    assign bus.overflow    = overflow_r;
    assign bus.done        = done_r;
endmodule

// File: tb/tb_out_channel_drain.sv
// tb_out_channel_drain
//
// Self-checking bench for out_channel_drain. A reference model of the
// buffered channel (a word queue plus run/drain/done phase) predicts status
// after each edge; accepted words are pushed to a scoreboard queue that an
// independent monitor pops whenever the DUT completes a stream handshake.
//
// Honours OUT_CHANNEL_DRAIN_CHECKSUM_EN the same way as the design.
module tb_out_channel_drain;
    localparam int W  = 12;
    localparam int N  = 6;

    typedef enum {M_RUN, M_DRAIN, M_DONE} phase_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] sb[$];
    phase_t       phase;
    logic         m_ovf;
    logic         m_done;
    logic [W-1:0] m_sum;
    logic [W-1:0] mon_exp;

    always #5 clock = ~clock;

    out_channel_drain_if #(.MemoryElementWidth(W), .NOut(N)) bus ();

    out_channel_drain #(.MemoryElementWidth(W), .NOut(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Generic comparison; every call is one counted comparison.
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advances the reference model across one clock edge given the inputs
    // that were held during the preceding cycle.
    task automatic modelEdge(input logic w, input logic [W-1:0] d,
                             input logic fin, input logic rdy);
        int   pre;
        logic rd;
        logic acc;
        pre = mq.size();
        rd  = (pre > 0) && rdy;
        acc = 1'b0;
        if (phase == M_RUN && w) begin
            if (pre < N || rd) acc = 1'b1;
            else               m_ovf = 1'b1;
        end
        if (rd) m_sum = m_sum + mq.pop_front();
        if (acc) begin
            mq.push_back(d);
            sb.push_back(d);
        end
        if (phase == M_DRAIN && pre == 0) begin
            phase  = M_DONE;
            m_done = 1'b1;
        end else if (phase == M_RUN && fin) begin
            phase = M_DRAIN;
        end
    endtask

    task automatic checkOutput();
        logic [W-1:0] exp_sum;
`ifdef OUT_CHANNEL_DRAIN_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = '0;
`endif
        check("count",    32'(bus.count),       32'(mq.size()));
        check("full",     32'(bus.full),        32'(mq.size() == N));
        check("valid",    32'(bus.streamValid), 32'(mq.size() > 0));
        check("last",     32'(bus.streamLast),
              32'(phase == M_DRAIN && mq.size() == 1));
        check("overflow", 32'(bus.overflow),    32'(m_ovf));
        check("done",     32'(bus.done),        32'(m_done));
        check("checksum", 32'(bus.checksum),    32'(exp_sum));
    endtask

    task automatic applyStimulus(input logic w, input logic [W-1:0] d,
                                 input logic fin, input logic rdy);
        bus.outWrite    = w;
        bus.outData     = d;
        bus.finished    = fin;
        bus.streamReady = rdy;
        @(posedge clock);
        #1;
        modelEdge(w, d, fin, rdy);
        checkOutput();
    endtask

    // Pulls reset low away from the clock edge and checks that the outputs
    // clear at once, then releases it mid-cycle.
    task automatic doReset();
        bus.outWrite    = 1'b0;
        bus.outData     = '0;
        bus.finished    = 1'b0;
        bus.streamReady = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(bus.streamValid), 32'd0);
        check("rst_done",  32'(bus.done),        32'd0);
        check("rst_count", 32'(bus.count),       32'd0);
        mq.delete();
        sb.delete();
        phase  = M_RUN;
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_sum  = '0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        checkOutput();
    endtask

    // Monitor: every handshake the DUT completes must carry the oldest
    // word still owed by the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && bus.streamValid && bus.streamReady) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL stream_data: got %0d expected no word",
                             bus.streamData);
                end else begin
                    mon_exp = sb.pop_front();
                    check("stream_data", 32'(bus.streamData), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] vals [6];
        int sent;
        int cyc;
        logic w;
        logic [W-1:0] expected_sum;

        vals = '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};

        doReset();

        // Ordered run: finished rides with the final write so 11 is last.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vals[i], (i == 5), 1'b1);
        end
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);
`ifdef OUT_CHANNEL_DRAIN_CHECKSUM_EN
        expected_sum = 12'd72;
`else
        expected_sum = 12'd0;
`endif
        check("ordered_sum",  32'(bus.checksum), 32'(expected_sum));
        check("ordered_done", 32'(bus.done),     32'd1);
        check("ordered_sb",   32'(sb.size()),    32'd0);

        // Overflow: seven writes with the consumer stalled.
        doReset();
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
        end
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Simultaneous write and read while full.
        doReset();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 12'd9, 1'b0, 1'b1);
        check("full_rw_count", 32'(bus.count),    32'd6);
        check("full_rw_ovf",   32'(bus.overflow), 32'd0);
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Wrap-around: 20 words with ready toggling every cycle.
        doReset();
        sent = 0;
        cyc  = 0;
        while (sent < 20 && cyc < 200) begin
            w = (mq.size() < N);
            applyStimulus(w, W'($urandom), 1'b0, cyc[0]);
            if (w) sent++;
            cyc++;
        end
        repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        check("wrap_ovf", 32'(bus.overflow), 32'd0);
        check("wrap_sb",  32'(sb.size()),    32'd0);

        // Randomised traffic ending in a drain.
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom),
                          (i >= 250 && $urandom_range(0, 7) == 0) || i == 299,
                          ($urandom_range(0, 2) == 0));
        end
        repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        check("rand_done", 32'(bus.done), 32'd1);
        check("rand_sb",   32'(sb.size()), 32'd0);

        // Finish with an empty buffer.
        doReset();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        check("empty_not_yet", 32'(bus.done), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        check("empty_done", 32'(bus.done), 32'd1);
        repeat (2) applyStimulus(1'b1, 12'd5, 1'b0, 1'b1);

        // Reset while draining with three words held.
        doReset();
        applyStimulus(1'b1, 12'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd6, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        check("drain_held", 32'(bus.count), 32'd3);
        doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
